// File: rtl/prbs_checker_if.sv
// Receive-side PRBS checker bus: the recovered data bit and counter clear
// flow into the checker; lock status, per-bit error pulse and the BER
// counters flow back out.
interface prbs_checker_if #(
  parameter int CNT_WIDTH = 32
) ();

  logic                 d_in;
  logic                 clr_counts;
  logic                 locked;
  logic                 bit_err;
  logic [CNT_WIDTH-1:0] bit_count;
  logic [CNT_WIDTH-1:0] err_count;

  // Data source / status consumer side (CDR plus measurement logic).
  modport master (
    output d_in,
    output clr_counts,
    input  locked,
    input  bit_err,
    input  bit_count,
    input  err_count
  );

  // Checker side.
  modport slave (
    input  d_in,
    input  clr_counts,
    output locked,
    output bit_err,
    output bit_count,
    output err_count
  );

endinterface

// File: rtl/prbs_checker.sv
// PRBS7 (x^7 + x^6 + 1) checker on the recovered bit clock. Seeds its LFSR
// from the incoming stream, confirms LOCK_COUNT consecutive predictions,
// then free-runs the LFSR so each line error is flagged exactly once.
// Loss of lock is declared when UNLOCK_ERRORS errors land in one WINDOW.
module prbs_checker #(
  parameter int LOCK_COUNT    = 32,
  parameter int WINDOW        = 64,
  parameter int UNLOCK_ERRORS = 8,
  parameter int CNT_WIDTH     = 32
) (
  input  logic          clk_bit,
  input  logic          rst,
  prbs_checker_if.slave bus
);

  localparam int MC_W = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT) : 1;
  localparam int WC_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int WE_W = $clog2(UNLOCK_ERRORS + 1);

  localparam logic [MC_W-1:0]      MATCH_LAST = MC_W'(LOCK_COUNT - 1);
  localparam logic [WC_W-1:0]      WIN_LAST   = WC_W'(WINDOW - 1);
  localparam logic [WE_W-1:0]      ERR_LIMIT  = WE_W'(UNLOCK_ERRORS);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX    = {CNT_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    ST_SEED    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  // Next PRBS7 bit predicted from the 7-bit history (bit 0 newest).
  function automatic logic prbs7_predict(input logic [6:0] hist);
    return hist[6] ^ hist[5];
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] value);
    return (value == CNT_MAX) ? value : value + CNT_WIDTH'(1);
  endfunction

  state_t               state_r, state_nxt_s;
  logic [6:0]           lfsr_r, lfsr_nxt_s;
  logic [2:0]           seed_cnt_r, seed_cnt_nxt_s;
  logic [MC_W-1:0]      match_cnt_r, match_cnt_nxt_s;
  logic [WC_W-1:0]      win_cnt_r, win_cnt_nxt_s;
  logic [WE_W-1:0]      win_err_r, win_err_nxt_s, win_err_inc_s;
  logic                 locked_r, locked_nxt_s;
  logic                 bit_err_r, bit_err_nxt_s;
  logic [CNT_WIDTH-1:0] bit_count_r, bit_count_nxt_s;
  logic [CNT_WIDTH-1:0] err_count_r, err_count_nxt_s;
  logic                 pred_s;
  logic                 mismatch_s;
  logic                 bit_inc_s;
  logic                 err_inc_s;

  assign pred_s        = prbs7_predict(lfsr_r);
  assign mismatch_s    = bus.d_in ^ pred_s;
  assign win_err_inc_s = win_err_r + WE_W'(1);

  // Next-state, LFSR, window and counter-increment decisions for one bit.
  always_comb begin
    state_nxt_s     = state_r;
    lfsr_nxt_s      = lfsr_r;
    seed_cnt_nxt_s  = seed_cnt_r;
    match_cnt_nxt_s = match_cnt_r;
    win_cnt_nxt_s   = win_cnt_r;
    win_err_nxt_s   = win_err_r;
    bit_err_nxt_s   = 1'b0;
    bit_inc_s       = 1'b0;
    err_inc_s       = 1'b0;

    case (state_r)
      ST_SEED: begin
        lfsr_nxt_s = {lfsr_r[5:0], bus.d_in};
        if (seed_cnt_r == 3'd6) begin
          state_nxt_s     = ST_ACQUIRE;
          seed_cnt_nxt_s  = 3'd0;
          match_cnt_nxt_s = {MC_W{1'b0}};
        end else begin
          seed_cnt_nxt_s = seed_cnt_r + 3'd1;
        end
      end

      ST_ACQUIRE: begin
        // Keep loading the line so a false start re-seeds from fresh data.
        lfsr_nxt_s = {lfsr_r[5:0], bus.d_in};
        if (!mismatch_s && (lfsr_r != 7'd0)) begin
          if (match_cnt_r == MATCH_LAST) begin
            state_nxt_s     = ST_LOCKED;
            match_cnt_nxt_s = {MC_W{1'b0}};
            win_cnt_nxt_s   = {WC_W{1'b0}};
            win_err_nxt_s   = {WE_W{1'b0}};
          end else begin
            match_cnt_nxt_s = match_cnt_r + MC_W'(1);
          end
        end else begin
          // Mismatch or all-zero lock-up: restart the whole acquisition.
          state_nxt_s     = ST_SEED;
          seed_cnt_nxt_s  = 3'd0;
          match_cnt_nxt_s = {MC_W{1'b0}};
        end
      end

      ST_LOCKED: begin
        // Free-run on our own prediction so a line error cannot propagate.
        lfsr_nxt_s = {lfsr_r[5:0], pred_s};
        bit_inc_s  = 1'b1;
        if (mismatch_s) begin
          bit_err_nxt_s = 1'b1;
          err_inc_s     = 1'b1;
        end else begin
          bit_err_nxt_s = 1'b0;
        end

        if (mismatch_s && (win_err_inc_s == ERR_LIMIT)) begin
          state_nxt_s    = ST_SEED;
          seed_cnt_nxt_s = 3'd0;
          win_cnt_nxt_s  = {WC_W{1'b0}};
          win_err_nxt_s  = {WE_W{1'b0}};
        end else if (win_cnt_r == WIN_LAST) begin
          win_cnt_nxt_s = {WC_W{1'b0}};
          win_err_nxt_s = {WE_W{1'b0}};
        end else begin
          win_cnt_nxt_s = win_cnt_r + WC_W'(1);
          win_err_nxt_s = mismatch_s ? win_err_inc_s : win_err_r;
        end
      end

      default: begin
        state_nxt_s     = ST_SEED;
        seed_cnt_nxt_s  = 3'd0;
        match_cnt_nxt_s = {MC_W{1'b0}};
        win_cnt_nxt_s   = {WC_W{1'b0}};
        win_err_nxt_s   = {WE_W{1'b0}};
      end
    endcase

    locked_nxt_s = (state_nxt_s == ST_LOCKED);

    // Clear takes priority over a same-cycle increment.
    if (bus.clr_counts) begin
      bit_count_nxt_s = {CNT_WIDTH{1'b0}};
      err_count_nxt_s = {CNT_WIDTH{1'b0}};
    end else begin
      bit_count_nxt_s = bit_inc_s ? sat_inc(bit_count_r) : bit_count_r;
      err_count_nxt_s = err_inc_s ? sat_inc(err_count_r) : err_count_r;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_bit) begin
    if (rst) begin
      state_r     <= ST_SEED;
      lfsr_r      <= 7'd0;
      seed_cnt_r  <= 3'd0;
      match_cnt_r <= {MC_W{1'b0}};
      win_cnt_r   <= {WC_W{1'b0}};
      win_err_r   <= {WE_W{1'b0}};
      locked_r    <= 1'b0;
      bit_err_r   <= 1'b0;
      bit_count_r <= {CNT_WIDTH{1'b0}};
      err_count_r <= {CNT_WIDTH{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      lfsr_r      <= lfsr_nxt_s;
      seed_cnt_r  <= seed_cnt_nxt_s;
      match_cnt_r <= match_cnt_nxt_s;
      win_cnt_r   <= win_cnt_nxt_s;
      win_err_r   <= win_err_nxt_s;
      locked_r    <= locked_nxt_s;
      bit_err_r   <= bit_err_nxt_s;
      bit_count_r <= bit_count_nxt_s;
      err_count_r <= err_count_nxt_s;
    end
  end

  assign bus.locked    = locked_r;
  assign bus.bit_err   = bit_err_r;
  assign bus.bit_count = bit_count_r;
  assign bus.err_count = err_count_r;

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: a default instance and a 4-bit-counter instance see
// the same stream. Expectations come from a bit-level view of the link: the
// bench knows which bits it corrupted, that lock takes 39 clean bits, and
// that 8 corrupted bits in one 64-bit block of checked bits drop lock.
module tb_prbs_checker;

  localparam int LOCK_BITS  = 7 + 32;
  localparam int WIN_BITS   = 64;
  localparam int UNLOCK_ERR = 8;

  logic clk_bit = 1'b0;
  logic rst;

  always #5 clk_bit = ~clk_bit;

  prbs_checker_if #(.CNT_WIDTH(32)) bus32 ();
  prbs_checker_if #(.CNT_WIDTH(4))  bus4 ();

  prbs_checker #(.LOCK_COUNT(32), .WINDOW(64), .UNLOCK_ERRORS(8), .CNT_WIDTH(32)) dut32 (
    .clk_bit(clk_bit), .rst(rst), .bus(bus32.slave)
  );

  prbs_checker #(.LOCK_COUNT(32), .WINDOW(64), .UNLOCK_ERRORS(8), .CNT_WIDTH(4)) dut4 (
    .clk_bit(clk_bit), .rst(rst), .bus(bus4.slave)
  );

  int     n_checks = 0;
  int     n_errors = 0;
  int     obs_pulses = 0;
  bit     gen_q[$];
  bit     m_locked;
  int     m_run;
  int     m_idx;
  int     m_cur_win;
  int     m_win_errs;
  longint m_bits;
  longint m_errs;
  bit     m_bit_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic seed_gen(input logic [6:0] s);
    logic [6:0] sv;
    sv = s;
    gen_q.delete();
    for (int i = 0; i < 7; i++) gen_q.push_back(sv[i]);
  endtask

  // s[n] = s[n-7] ^ s[n-6]
  task automatic prbs_next(output bit b);
    b = gen_q[0];
    gen_q.push_back(gen_q[0] ^ gen_q[1]);
    void'(gen_q.pop_front());
  endtask

  function automatic logic [31:0] sat4(input longint v);
    return (v > 15) ? 32'd15 : 32'(v);
  endfunction

  // One bit time: drive, clock, update the reference, check every output.
  task automatic step(input bit do_rst, input bit force_en, input bit force_val,
                      input bit inj, input bit clr);
    bit b;
    bit d;
    @(negedge clk_bit);
    prbs_next(b);
    d = force_en ? force_val : (b ^ inj);
    rst = do_rst;
    bus32.d_in = d;
    bus4.d_in = d;
    bus32.clr_counts = clr;
    bus4.clr_counts = clr;
    @(posedge clk_bit);
    m_bit_err = 1'b0;
    if (do_rst) begin
      m_locked = 1'b0;
      m_run = 0;
      m_bits = 0;
      m_errs = 0;
    end else begin
      if (m_locked) begin
        if ((m_idx / WIN_BITS) != m_cur_win) begin
          m_cur_win = m_idx / WIN_BITS;
          m_win_errs = 0;
        end
        m_idx++;
        m_bits++;
        if (inj) begin
          m_bit_err = 1'b1;
          m_errs++;
          m_win_errs++;
          if (m_win_errs == UNLOCK_ERR) begin
            m_locked = 1'b0;
            m_run = 0;
          end
        end
      end else if (force_en || inj) begin
        m_run = 0;
      end else begin
        m_run++;
        if (m_run == LOCK_BITS) begin
          m_locked = 1'b1;
          m_idx = 0;
          m_cur_win = 0;
          m_win_errs = 0;
        end
      end
      if (clr) begin
        m_bits = 0;
        m_errs = 0;
      end
    end
    #1;
    check("locked", {31'd0, bus32.locked}, {31'd0, m_locked});
    check("bit_err", {31'd0, bus32.bit_err}, {31'd0, m_bit_err});
    check("bit_count", bus32.bit_count, 32'(m_bits));
    check("err_count", bus32.err_count, 32'(m_errs));
    check("locked_w4", {31'd0, bus4.locked}, {31'd0, m_locked});
    check("bit_count_w4", {28'd0, bus4.bit_count}, sat4(m_bits));
    check("err_count_w4", {28'd0, bus4.err_count}, sat4(m_errs));
    if (bus32.bit_err === 1'b1) obs_pulses++;
  endtask

  task automatic clean(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Advance to the first bit of a fresh 64-bit block of checked bits.
  task automatic align_window();
    int guard;
    guard = 0;
    while (!(m_locked && (m_idx % WIN_BITS) == 0) && guard < 200) begin
      clean(1);
      guard++;
    end
    check("align_timeout", guard, (guard < 200) ? guard : 0);
  endtask

  initial begin
    int p0;
    bit lk_seen;
    bit inj;
    bit clr;
    bit r;

    rst = 1'b1;
    bus32.d_in = 1'b0;
    bus4.d_in = 1'b0;
    bus32.clr_counts = 1'b0;
    bus4.clr_counts = 1'b0;
    m_locked = 1'b0;
    m_run = 0;
    m_idx = 0;
    m_cur_win = 0;
    m_win_errs = 0;
    m_bits = 0;
    m_errs = 0;
    seed_gen(7'h7F);

    // Reset state.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_locked", {31'd0, bus32.locked}, 32'd0);
    check("rst_bit_count", bus32.bit_count, 32'd0);

    // Clean acquisition: lock exactly after edge 39.
    clean(38);
    check("prelock_edge38", {31'd0, bus32.locked}, 32'd0);
    clean(1);
    check("lock_edge39", {31'd0, bus32.locked}, 32'd1);
    p0 = obs_pulses;
    clean(1000);
    check("clean_bits_1000", bus32.bit_count, 32'd1000);
    check("clean_errs_0", bus32.err_count, 32'd0);
    check("clean_no_pulse", obs_pulses - p0, 32'd0);

    // Single inverted bit.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("single_pulse", {31'd0, bus32.bit_err}, 32'd1);
    check("single_err1", bus32.err_count, 32'd1);
    clean(1);
    check("single_pulse_ends", {31'd0, bus32.bit_err}, 32'd0);
    check("single_still_locked", {31'd0, bus32.locked}, 32'd1);

    // Eight errors in one window drop lock; relock after 39 clean bits.
    align_window();
    p0 = obs_pulses;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      if (i < 7) clean(1);
    end
    check("unlock_after_8th", {31'd0, bus32.locked}, 32'd0);
    check("unlock_pulses_8", obs_pulses - p0, 32'd8);
    check("unlock_errs_9", bus32.err_count, 32'd9);
    clean(38);
    check("relock_not_yet", {31'd0, bus32.locked}, 32'd0);
    clean(1);
    check("relock_39", {31'd0, bus32.locked}, 32'd1);
    check("relock_errs_kept", bus32.err_count, 32'd9);

    // Seven errors in each of two consecutive windows keep lock.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    align_window();
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      clean(3);
    end
    align_window();
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      clean(3);
    end
    check("split_still_locked", {31'd0, bus32.locked}, 32'd1);
    check("split_errs_14", bus32.err_count, 32'd14);

    // Constant-0 then constant-1 streams never lock.
    for (int v = 0; v < 2; v++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      lk_seen = 1'b0;
      for (int i = 0; i < 500; i++) begin
        step(1'b0, 1'b1, v[0], 1'b0, 1'b0);
        lk_seen = lk_seen | bus32.locked;
      end
      check("const_never_locked", {31'd0, lk_seen}, 32'd0);
      check("const_bits_0", bus32.bit_count, 32'd0);
    end

    // Saturation on the 4-bit instance, clear on an error edge, reset while locked.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    clean(LOCK_BITS);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      clean(15);
    end
    check("sat_err32_20", bus32.err_count, 32'd20);
    check("sat_err4_15", {28'd0, bus4.err_count}, 32'd15);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("clr_on_err_count", {28'd0, bus4.err_count}, 32'd0);
    check("clr_on_err_pulse", {31'd0, bus4.bit_err}, 32'd1);
    clean(3);
    check("pre_rst_locked", {31'd0, bus32.locked}, 32'd1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_locked_0", {31'd0, bus32.locked}, 32'd0);
    check("rst_bits_0", bus32.bit_count, 32'd0);

    // Randomized phase: random seed, sparse errors, clears and resets.
    seed_gen(7'($urandom_range(1, 127)));
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      inj = m_locked && ($urandom_range(0, 29) == 0);
      clr = ($urandom_range(0, 249) == 0);
      r   = ($urandom_range(0, 999) == 0);
      step(r, 1'b0, 1'b0, inj, clr);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/prbs_checker.md
# prbs_checker

PRBS7 checker (x^7 + x^6 + 1) for the fibre link receive path. Sits directly downstream of clock_data_recovery: consumes the recovered bit stream (rx_out) on the recovered bit clock, self-synchronises to the transmitter's PRBS and reports lock, per-bit errors and saturating bit/error counts for BER measurement. Pairs with the tx block's PRBS mode (prbs_on).

## Interface

Parameters:
- LOCK_COUNT, 32: consecutive correct predictions required to declare lock (≥1).
- WINDOW, 64: loss-of-lock observation window in bits (≥UNLOCK_ERRORS).
- UNLOCK_ERRORS, 8: errors within one window that force loss of lock (≥1).
- CNT_WIDTH, 32: width of bit_count and err_count.

Ports:
- clk_bit  input  1  recovered bit clock (clk_out of clock_data_recovery); single clock domain.
- rst  input  1  synchronous, active-high reset.
- d_in  input  1  recovered data bit, sampled every rising edge.
- clr_counts  input  1  synchronous clear of bit_count/err_count.
- locked  output  1  high while in LOCKED.
- bit_err  output  1  one-cycle pulse per mismatched bit while LOCKED.
- bit_count  output  CNT_WIDTH  bits checked while LOCKED, saturating.
- err_count  output  CNT_WIDTH  errors detected while LOCKED, saturating.

## Operation

- 7-bit register lfsr; lfsr[0] newest bit. Prediction p = lfsr[6] ^ lfsr[5].
- States: SEED, ACQUIRE, LOCKED.
- SEED: lfsr <= {lfsr[5:0], d_in}; seed_cnt counts 0..6; on seed_cnt==6 -> ACQUIRE, match_cnt <= 0.
- ACQUIRE: lfsr still loads d_in (self-synchronising). If d_in==p and lfsr!=0: match_cnt++; on match with match_cnt==LOCK_COUNT-1 -> LOCKED. If d_in!=p or lfsr==0 (all-zero lock-up guard): -> SEED, seed_cnt <= 0. No bit_err, no counting in ACQUIRE.
- LOCKED: lfsr free-runs, lfsr <= {lfsr[5:0], p}, so a single line error yields exactly one bit_err, not three. Each bit: bit_count++; if d_in!=p: bit_err pulse, err_count++, win_err++.
- Window: win_cnt counts 0..WINDOW-1 in LOCKED, wraps to 0 and clears win_err on wrap. If an error brings win_err to UNLOCK_ERRORS -> SEED (seed_cnt, win_cnt, win_err <= 0); that final error is still pulsed and counted.
- Counters saturate at all-ones; never wrap.
- clr_counts: bit_count, err_count <= 0 next edge; clear wins over a simultaneous increment. Does not affect state, lfsr, window or bit_err.

## Timing

- Reset values: locked 0, bit_err 0, bit_count 0, err_count 0, state SEED, lfsr 0, all internal counters 0.
- Reset mid-operation: all of the above restored on the same edge; in-progress lock abandoned.
- All outputs registered. bit_err high the cycle after the erroneous d_in edge; counts update on that same edge.
- Clean PRBS7 from reset release: 7 seed edges + LOCK_COUNT match edges; locked high after edge 7+LOCK_COUNT (39 for defaults). First checked bit is the one sampled on edge 40.
- Loss of lock: locked low the cycle after the UNLOCK_ERRORS-th error edge; relock needs ≥7+LOCK_COUNT further bits.
- Any mismatch in ACQUIRE restarts the full 7+LOCK_COUNT sequence.
- Tolerates no d_in gaps: every clk_bit edge is one bit.

## Test plan

- Clean PRBS7 (seed 7'h7F), defaults -> locked rises after edge 39; after 1000 further bits bit_count==1000, err_count==0, bit_err never high.
- Locked, invert one d_in bit -> exactly one bit_err pulse one cycle later, err_count==1, locked stays high.
- Locked, invert 8 bits within a 64-bit window -> 8 bit_err pulses, err_count==8, locked low the cycle after the 8th; clean stream relocks 39 bits later with counts preserved.
- Invert 7 bits in a window, then 7 in the next window -> locked stays high, err_count==14.
- d_in held constant 0 (and separately 1) for 500 bits -> locked never asserts, counts stay 0.
- CNT_WIDTH=4: 20 errors spaced 16 bits apart -> err_count saturates at 15; clr_counts on an error edge -> err_count==0 next cycle, bit_err still pulses; rst asserted while locked -> all outputs 0 next edge.
